rfifo_example_rfifo: RTL and testbench

//  Single-clock, first-word-fall-through read FIFO that feeds the register block's
//  REG_WITH_RFIFO.read_data field. Hardware pushes data words on the write side.
//  The APB register block reads the head word combinationally and pops it with a
//  one-cycle rinc pulse. Sticky overflow/underflow flags and a fill count support

---
 rtl/rfifo_example_rfifo.sv | 67 ++++++
 tb/tb_rfifo_example_rfifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rfifo_example_rfifo.sv
// First-word-fall-through read FIFO feeding a register read_data field; head word is combinational, pop/push take effect at the edge.
// Pushes while full are dropped (sticky overflow) unless a pop is in the same cycle; pops while empty are ignored (sticky underflow).
module rfifo_example_rfifo #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    DEPTH       = 8,
    parameter logic [DATA_WIDTH-1:0] EMPTY_VALUE = '0,
    localparam int                   AW          = $clog2(DEPTH)
) (
    input  logic                  RegClk,
    input  logic                  RegReset_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  winc,
    output logic                  wfull,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  rinc,
    output logic                  rempty,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [AW:0]           wptr;
    logic [AW:0]           rptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  push_ok;
    logic                  pop_ok;

    assign rempty    = (wptr == rptr);
    assign wfull     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count     = wptr - rptr;
    assign read_data = rempty ? EMPTY_VALUE : mem[rptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok = winc && (!wfull || rinc);
    assign pop_ok  = rinc && !rempty;

    always_ff @(posedge RegClk or negedge RegReset_n) begin
        if (!RegReset_n) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop_ok)
                rptr <= rptr + 1'b1;
            if (winc && wfull && !rinc)
                overflow <= 1'b1;
            if (rinc && rempty)
                underflow <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge RegClk) begin
        if (push_ok && !flush)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: tb/tb_rfifo_example_rfifo.sv
module tb_rfifo_example_rfifo;

    logic       RegClk = 1'b0;
    logic       RegReset_n;
    logic       flush;
    logic [7:0] wdata;
    logic       winc;
    logic       wfull;
    logic [7:0] read_data;
    logic       rinc;
    logic       rempty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of words plus the two sticky flags.
    logic [7:0] q [$];
    logic       m_ovf;
    logic       m_udf;

    logic [15:0] dut_vec;
    assign dut_vec = {rempty, wfull, overflow, underflow, count, read_data};

    always #5 RegClk = ~RegClk;

    rfifo_example_rfifo #(.DATA_WIDTH(8), .DEPTH(8), .EMPTY_VALUE(8'h00)) dut (
        .RegClk     (RegClk),
        .RegReset_n (RegReset_n),
        .flush      (flush),
        .wdata      (wdata),
        .winc       (winc),
        .wfull      (wfull),
        .read_data  (read_data),
        .rinc       (rinc),
        .rempty     (rempty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    function automatic logic [15:0] exp_vec();
        logic [7:0] rd;
        rd = (q.size() != 0) ? q[0] : 8'h00;
        return {q.size() == 0, q.size() == 8, m_ovf, m_udf, 4'(q.size()), rd};
    endfunction

    function automatic void model_clear();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endfunction

    function automatic void model_edge(input logic w, input logic [7:0] d, input logic r, input logic f);
        logic was_full;
        logic was_empty;
        if (f) begin
            model_clear();
            return;
        end
        was_full  = (q.size() == 8);
        was_empty = (q.size() == 0);
        if (r && was_empty)
            m_udf = 1'b1;
        if (w && was_full && !r)
            m_ovf = 1'b1;
        if (r && !was_empty)
            void'(q.pop_front());
        if (w && (!was_full || r))
            q.push_back(d);
    endfunction

    // One clock cycle with the given inputs; returns #1 after the edge with inputs idle.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f);
        winc  = w;
        wdata = d;
        rinc  = r;
        flush = f;
        @(posedge RegClk);
        model_edge(w, d, r, f);
        #1;
        winc  = 1'b0;
        rinc  = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        RegReset_n = 1'b0;
        winc = 1'b0; rinc = 1'b0; flush = 1'b0; wdata = 8'h00;
        model_clear();
        repeat (2) @(posedge RegClk);
        @(negedge RegClk);
        RegReset_n = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 16'h8000) begin
            errors++;
            $display("FAIL reset_state got %h expected %h", dut_vec, 16'h8000);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++)
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
        checks++;
        if ({wfull, count, read_data, rempty} !== {1'b1, 4'd8, 8'h01, 1'b0}) begin
            errors++;
            $display("FAIL fill got wfull=%b count=%0d rd=%h rempty=%b expected 1 8 01 0",
                     wfull, count, read_data, rempty);
        end
    endtask

    task automatic test_overflow_drain();
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        checks++;
        if ({overflow, count} !== {1'b1, 4'd8}) begin
            errors++;
            $display("FAIL overflow got ovf=%b count=%0d expected 1 8", overflow, count);
        end
        for (int i = 1; i <= 8; i++) begin
            rinc = 1'b1;
            #1;
            checks++;
            if (read_data !== 8'(i)) begin
                errors++;
                $display("FAIL drain_%0d got %h expected %h", i, read_data, 8'(i));
            end
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++;
        if ({rempty, read_data, count} !== {1'b1, 8'h00, 4'd0}) begin
            errors++;
            $display("FAIL drained got rempty=%b rd=%h count=%0d expected 1 00 0", rempty, read_data, count);
        end
    endtask

    task automatic test_underflow_flush();
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({underflow, count, rempty} !== {1'b1, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL underflow got udf=%b count=%0d rempty=%b expected 1 0 1", underflow, count, rempty);
        end
        // A push concurrent with flush must be discarded.
        cyc(1'b1, 8'h3C, 1'b0, 1'b1);
        checks++;
        if ({underflow, overflow, count, rempty} !== {1'b0, 1'b0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL flush got udf=%b ovf=%b count=%0d rempty=%b expected 0 0 0 1",
                     underflow, overflow, count, rempty);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 8; i++)
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        checks++;
        if ({count, overflow, read_data} !== {4'd8, 1'b0, 8'h02}) begin
            errors++;
            $display("FAIL full_push_pop got count=%0d ovf=%b rd=%h expected 8 0 02", count, overflow, read_data);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (read_data !== ((i == 7) ? 8'h55 : 8'(i + 2))) begin
                errors++;
                $display("FAIL full_pp_order_%0d got %h expected %h", i, read_data,
                         (i == 7) ? 8'h55 : 8'(i + 2));
            end
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++;
        if (rempty !== 1'b1) begin
            errors++;
            $display("FAIL full_pp_empty got %b expected 1", rempty);
        end
    endtask

    task automatic test_wrap();
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            if (read_data !== 8'(8'h10 + i) || count !== 4'd1) begin
                bad++;
                $display("FAIL wrap_push_%0d got rd=%h count=%0d expected %h 1", i, read_data, count, 8'(8'h10 + i));
            end
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            if (rempty !== 1'b1 || count !== 4'd0) begin
                bad++;
                $display("FAIL wrap_pop_%0d got rempty=%b count=%0d expected 1 0", i, rempty, count);
            end
        end
        checks++;
        errors += bad;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        #2;
        RegReset_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({rempty, count, read_data} !== {1'b1, 4'd0, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid got rempty=%b count=%0d rd=%h expected 1 0 00", rempty, count, read_data);
        end
        @(negedge RegClk);
        RegReset_n = 1'b1;
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        checks++;
        if ({read_data, count} !== {8'h77, 4'd1}) begin
            errors++;
            $display("FAIL reset_mid_push got rd=%h count=%0d expected 77 1", read_data, count);
        end
    endtask

    task automatic test_random();
        int bad;
        int wp;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            wp = (i % 200 < 100) ? 75 : 30;
            cyc($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < 50,
                $urandom_range(0, 59) == 0);
            if (dut_vec !== exp_vec()) begin
                bad++;
                if (bad <= 10)
                    $display("FAIL random_%0d got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        errors += bad;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow_flush();
        test_full_push_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
